uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame.sv | 116 +++++++++++
 tb/tb_uart_tx_frame.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, IN_width data bits LSB-first, optional parity, stop bit.
// Define UART_TX_PAR_INT_EN to compute parity from the accepted word instead of using par_bit.
module uart_tx_frame #(
  parameter int IN_width = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [IN_width-1:0] P_DATA,
  input  logic                DATA_valid,
  input  logic                PAR_EN,
  input  logic                PAR_TYP,
  input  logic                par_bit,
  output logic                TX_OUT,
  output logic                BUSY
);

  localparam int CntW = $clog2(IN_width);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IN_width-1:0] shift_q, shift_d;
  logic                parEn_q, parEn_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                parSrc;
  logic                accept;
  logic                lastBit;

  assign accept  = DATA_valid && ((state_q == IDLE) || (state_q == STOP));
  assign lastBit = (cnt_q == CntW'(IN_width - 1));

`ifdef UART_TX_PAR_INT_EN
  logic parity_q, parity_d;
  logic unusedParBit;
  assign unusedParBit = par_bit;
  assign parSrc       = parity_q;
`else
  logic unusedParTyp;
  assign unusedParTyp = PAR_TYP;
  assign parSrc       = par_bit;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      parEn_q  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PAR_INT_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      parEn_q  <= parEn_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PAR_INT_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (DATA_valid) state_d = START;
      START:   state_d = DATA;
      DATA:    if (lastBit) state_d = parEn_q ? PARITY : STOP;
      PARITY:  state_d = STOP;
      STOP:    state_d = DATA_valid ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch on accept, otherwise shift and count only while sending data bits.
  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    parEn_d  = parEn_q;
`ifdef UART_TX_PAR_INT_EN
    parity_d = parity_q;
`endif
    if (accept) begin
      shift_d  = P_DATA;
      parEn_d  = PAR_EN;
`ifdef UART_TX_PAR_INT_EN
      parity_d = (^P_DATA) ^ PAR_TYP;
`endif
    end else if (state_q == DATA) begin
      shift_d = shift_q >> 1;
      cnt_d   = lastBit ? '0 : cnt_q + 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parSrc;
      default: tx_d = 1'b1;
    endcase
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed frames plus randomized frames against a frame-list model.
module tb_uart_tx_frame;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       par_bit;
  logic       TX_OUT;
  logic       BUSY;

  int checks = 0;
  int errors = 0;
  bit expQ[$];

  logic [7:0] rd;
  bit         rpe, rpb, rpt;

  uart_tx_frame #(.IN_width(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_valid (DATA_valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .par_bit    (par_bit),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic bit modelParity(input logic [7:0] d, input bit pb, input bit pt);
`ifdef UART_TX_PAR_INT_EN
    return (^d) ^ pt;
`else
    return pb;
`endif
  endfunction

  // Expected line levels for one whole frame, start bit first.
  task automatic buildFrame(input logic [7:0] d, input bit pe, input bit pb, input bit pt);
    expQ.delete();
    expQ.push_back(1'b0);
    for (int i = 0; i < 8; i++) expQ.push_back(d[i]);
    if (pe) expQ.push_back(modelParity(d, pb, pt));
    expQ.push_back(1'b1);
  endtask

  task automatic checkOutput(input string tag, input logic expTx, input logic expBusy);
    checks++;
    assert (TX_OUT === expTx) else begin
      errors++;
      $error("[TB] FAIL %s TX_OUT got %b expected %b", tag, TX_OUT, expTx);
    end
    checks++;
    assert (BUSY === expBusy) else begin
      errors++;
      $error("[TB] FAIL %s BUSY got %b expected %b", tag, BUSY, expBusy);
    end
  endtask

  // Presents a word for one accepting edge; returns at the negedge showing the start bit.
  task automatic applyStimulus(input logic [7:0] d, input bit pe, input bit pb, input bit pt);
    P_DATA     = d;
    PAR_EN     = pe;
    par_bit    = pb;
    PAR_TYP    = pt;
    DATA_valid = 1'b1;
    @(negedge CLK);
    DATA_valid = 1'b0;
  endtask

  task automatic checkFrame(input logic [7:0] d, input bit pe, input bit pb, input bit pt, input bit noise);
    int n;
    buildFrame(d, pe, pb, pt);
    n = expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("frame%02h_bit%0d", d, i), expQ[i], 1'b1);
      if (noise) begin
        DATA_valid = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        P_DATA     = 8'($urandom);
        PAR_EN     = 1'($urandom_range(0, 1));
        PAR_TYP    = 1'($urandom_range(0, 1));
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    RST        = 1'b0;
    P_DATA     = 8'h00;
    DATA_valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    par_bit    = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("reset", 1'b1, 1'b0);
    RST = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      checkOutput("idle", 1'b1, 1'b0);
    end

    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0);
    checkFrame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("a5_after", 1'b1, 1'b0);

    applyStimulus(8'h0F, 1'b0, 1'b0, 1'b0);
    checkFrame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("0f_after", 1'b1, 1'b0);

    P_DATA     = 8'h55;
    PAR_EN     = 1'b0;
    DATA_valid = 1'b1;
    @(negedge CLK);
    P_DATA = 8'h33;
    checkFrame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    DATA_valid = 1'b0;
    checkFrame(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("b2b_after", 1'b1, 1'b0);

    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    buildFrame(8'hFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ff_bit%0d", i), expQ[i], 1'b1);
      @(negedge CLK);
    end
    checkOutput("ff_data3", expQ[4], 1'b1);
    RST        = 1'b0;
    DATA_valid = 1'b1;
    P_DATA     = 8'hAA;
    @(negedge CLK);
    checkOutput("rst_mid", 1'b1, 1'b0);
    RST        = 1'b1;
    DATA_valid = 1'b0;
    @(negedge CLK);
    checkOutput("rst_drop", 1'b1, 1'b0);

    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkFrame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("00_after", 1'b1, 1'b0);

`ifdef UART_TX_PAR_INT_EN
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b1);
    checkFrame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("intpar_after", 1'b1, 1'b0);
`endif

    repeat (10) begin
      rd  = 8'($urandom);
      rpe = 1'($urandom_range(0, 1));
      rpb = 1'($urandom_range(0, 1));
      rpt = 1'($urandom_range(0, 1));
      applyStimulus(rd, rpe, rpb, rpt);
      checkFrame(rd, rpe, rpb, rpt, 1'b1);
      checkOutput("rand_after", 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
